// File: rtl/rf80386_bus_arbiter.sv
// Two-requester arbiter for the rf80386 128-bit FTA master port: one outstanding
// transaction, rolling tid tagging, rty back-off re-issue and a timeout error response.
module rf80386_bus_arbiter #(
  parameter logic [5:0] CORENO    = 6'd1,
  parameter logic [2:0] CID       = 3'd1,
  parameter int         RTY_WAIT  = 5,    // must be >= 2
  parameter int         TMO       = 255,
  parameter int         MAXSTARVE = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic         r0_we,
  input  logic [31:0]  r0_adr,
  input  logic [15:0]  r0_sel,
  input  logic [127:0] r0_dat,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic         r1_we,
  input  logic [31:0]  r1_adr,
  input  logic [15:0]  r1_sel,
  input  logic [127:0] r1_dat,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic         rsp_err,
  output logic [127:0] rsp_dat,
  output logic         m_cyc,
  output logic         m_stb,
  output logic         m_we,
  output logic [31:0]  m_adr,
  output logic [15:0]  m_sel,
  output logic [127:0] m_dat,
  output logic [12:0]  m_tid,
  input  logic         m_ack,
  input  logic         m_rty,
  input  logic [12:0]  m_rtid,
  input  logic [127:0] m_rdat,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int TW = $clog2(TMO + 1);
  localparam int BW = $clog2(RTY_WAIT + 1);
  localparam int SW = $clog2(MAXSTARVE + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, BACKOFF = 2'd3} state_t;

  // Handshake: rN_valid is held with a stable command until rN_ready pulses for one
  // cycle; the pulse is registered, so it arrives the cycle after IDLE sampled valid,
  // and the command is already latched when the requester sees it.

  state_t          state_q, state_d;
  logic [3:0]      tid_q, tid_d, h_tid_q, h_tid_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [BW-1:0]   bo_q, bo_d;
  logic            retry_q, retry_d, g_q, g_d;
  logic            h_we_q, h_we_d;
  logic [31:0]     h_adr_q, h_adr_d;
  logic [15:0]     h_sel_q, h_sel_d;
  logic [127:0]    h_dat_q, h_dat_d;
  logic            r0_ready_q, r0_ready_d, r1_ready_q, r1_ready_d;
  logic            rsp0_q, rsp0_d, rsp1_q, rsp1_d, rsp_err_q, rsp_err_d;
  logic [127:0]    rsp_dat_q, rsp_dat_d;
  logic            m_cyc_q, m_cyc_d, m_stb_q, m_stb_d, m_we_q, m_we_d;
  logic [31:0]     m_adr_q, m_adr_d;
  logic [15:0]     m_sel_q, m_sel_d;
  logic [127:0]    m_dat_q, m_dat_d;
  logic [12:0]     m_tid_q, m_tid_d;
  logic            busy_q, busy_d;
  logic            grant1, match, fin, fin_err;

  always_comb begin
    state_d    = state_q;
    tid_d      = tid_q;
    h_tid_d    = h_tid_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    bo_d       = bo_q;
    retry_d    = retry_q;
    g_d        = g_q;
    h_we_d     = h_we_q;
    h_adr_d    = h_adr_q;
    h_sel_d    = h_sel_q;
    h_dat_d    = h_dat_q;
    r0_ready_d = 1'b0;
    r1_ready_d = 1'b0;
    rsp0_d     = 1'b0;
    rsp1_d     = 1'b0;
    rsp_err_d  = rsp_err_q;
    rsp_dat_d  = rsp_dat_q;
    m_cyc_d    = 1'b0;
    m_stb_d    = 1'b0;
    m_we_d     = 1'b0;
    m_adr_d    = '0;
    m_sel_d    = '0;
    m_dat_d    = '0;
    m_tid_d    = m_tid_q;
    busy_d     = (state_q != IDLE);
    grant1     = 1'b0;
    match      = (m_rtid == m_tid_q);
    fin        = 1'b0;
    fin_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          grant1     = r1_valid && (!r0_valid || starve_q == SW'(MAXSTARVE));
          g_d        = grant1;
          h_we_d     = grant1 ? r1_we  : r0_we;
          h_adr_d    = grant1 ? r1_adr : r0_adr;
          h_sel_d    = grant1 ? r1_sel : r0_sel;
          h_dat_d    = grant1 ? r1_dat : r0_dat;
          r0_ready_d = !grant1;
          r1_ready_d = grant1;
          h_tid_d    = tid_q;
          tid_d      = (tid_q == 4'd15) ? 4'd1 : tid_q + 4'd1;
          retry_d    = 1'b0;
          starve_d   = grant1 ? '0 : starve_q + 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        m_cyc_d = 1'b1;
        m_stb_d = 1'b1;
        m_we_d  = h_we_q;
        m_adr_d = h_adr_q;
        m_sel_d = h_sel_q;
        m_dat_d = h_dat_q;
        m_tid_d = {CORENO, CID, h_tid_q};
        // A re-issue keeps the original deadline running.
        tmo_d   = retry_q ? tmo_q + 1'b1 : '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (m_ack && match) begin
          fin = 1'b1;
        end else if (m_rty && match) begin
          bo_d    = '0;
          retry_d = 1'b1;
          state_d = BACKOFF;
        end else if (tmo_q >= TW'(TMO - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      BACKOFF: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q >= TW'(TMO - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (bo_q >= BW'(RTY_WAIT - 2)) begin
          state_d = ISSUE;
        end else begin
          bo_d = bo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      rsp0_d    = !g_q;
      rsp1_d    = g_q;
      rsp_err_d = fin_err;
      rsp_dat_d = fin_err ? '0 : m_rdat;
      state_d   = IDLE;
    end

    if (!r1_valid) starve_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tid_q      <= 4'd1;
      h_tid_q    <= '0;
      starve_q   <= '0;
      tmo_q      <= '0;
      bo_q       <= '0;
      retry_q    <= 1'b0;
      g_q        <= 1'b0;
      h_we_q     <= 1'b0;
      h_adr_q    <= '0;
      h_sel_q    <= '0;
      h_dat_q    <= '0;
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_dat_q  <= '0;
      m_cyc_q    <= 1'b0;
      m_stb_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_adr_q    <= '0;
      m_sel_q    <= '0;
      m_dat_q    <= '0;
      m_tid_q    <= {CORENO, CID, 4'd0};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tid_q      <= tid_d;
      h_tid_q    <= h_tid_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      bo_q       <= bo_d;
      retry_q    <= retry_d;
      g_q        <= g_d;
      h_we_q     <= h_we_d;
      h_adr_q    <= h_adr_d;
      h_sel_q    <= h_sel_d;
      h_dat_q    <= h_dat_d;
      r0_ready_q <= r0_ready_d;
      r1_ready_q <= r1_ready_d;
      rsp0_q     <= rsp0_d;
      rsp1_q     <= rsp1_d;
      rsp_err_q  <= rsp_err_d;
      rsp_dat_q  <= rsp_dat_d;
      m_cyc_q    <= m_cyc_d;
      m_stb_q    <= m_stb_d;
      m_we_q     <= m_we_d;
      m_adr_q    <= m_adr_d;
      m_sel_q    <= m_sel_d;
      m_dat_q    <= m_dat_d;
      m_tid_q    <= m_tid_d;
      busy_q     <= busy_d;
    end
  end

  assign r0_ready   = r0_ready_q;
  assign r1_ready   = r1_ready_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_dat    = rsp_dat_q;
  assign m_cyc      = m_cyc_q;
  assign m_stb      = m_stb_q;
  assign m_we       = m_we_q;
  assign m_adr      = m_adr_q;
  assign m_sel      = m_sel_q;
  assign m_dat      = m_dat_q;
  assign m_tid      = m_tid_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rf80386_bus_arbiter.sv
// Directed bench for rf80386_bus_arbiter: stimulus pushes expected strobes and
// responses into queues, a negedge monitor pops and compares them.
module tb_rf80386_bus_arbiter;
  localparam int RTY_WAIT = 5;
  localparam int TMO      = 255;
  localparam logic [8:0] PFX = {6'd1, 3'd1};

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         r0_valid, r0_ready, r0_we;
  logic [31:0]  r0_adr;
  logic [15:0]  r0_sel;
  logic [127:0] r0_dat;
  logic         r1_valid, r1_ready, r1_we;
  logic [31:0]  r1_adr;
  logic [15:0]  r1_sel;
  logic [127:0] r1_dat;
  logic         rsp0_valid, rsp1_valid, rsp_err;
  logic [127:0] rsp_dat;
  logic         m_cyc, m_stb, m_we;
  logic [31:0]  m_adr;
  logic [15:0]  m_sel;
  logic [127:0] m_dat;
  logic [12:0]  m_tid;
  logic         m_ack, m_rty;
  logic [12:0]  m_rtid;
  logic [127:0] m_rdat;
  logic         busy;
  logic [1:0]   dbg_state;

  rf80386_bus_arbiter #(
    .CORENO(6'd1), .CID(3'd1), .RTY_WAIT(RTY_WAIT), .TMO(TMO), .MAXSTARVE(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_adr(r0_adr),
    .r0_sel(r0_sel), .r0_dat(r0_dat),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_adr(r1_adr),
    .r1_sel(r1_sel), .r1_dat(r1_dat),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_err(rsp_err), .rsp_dat(rsp_dat),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat(m_dat), .m_tid(m_tid), .m_ack(m_ack), .m_rty(m_rty), .m_rtid(m_rtid),
    .m_rdat(m_rdat), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [190:0] exp_stb_q[$];  // {cyc, we, adr, sel, dat, tid}
  logic [129:0] exp_rsp_q[$];  // {requester, err, dat}
  logic [190:0] mon_stb;
  logic [129:0] mon_rsp;
  logic [3:0]   exp_tid;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rsp0_valid || rsp1_valid) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_unexpected", {rsp0_valid, rsp1_valid}, 2'b00);
        end else begin
          mon_rsp = exp_rsp_q.pop_front();
          check("rsp", {rsp0_valid & rsp1_valid, rsp1_valid, rsp_err, rsp_dat}, {1'b0, mon_rsp});
        end
      end
      if (m_stb || m_cyc) begin
        if (exp_stb_q.size() == 0) begin
          check("stb_unexpected", {m_cyc, m_stb}, 2'b00);
        end else begin
          mon_stb = exp_stb_q.pop_front();
          check("stb", {m_stb, m_cyc, m_we, m_adr, m_sel, m_dat, m_tid}, {1'b1, mon_stb});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_stb(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                          input logic [127:0] dat, input logic [3:0] tid);
    exp_stb_q.push_back({1'b1, we, adr, sel, dat, PFX, tid});
  endtask

  task automatic push_rsp(input logic req, input logic err, input logic [127:0] dat);
    exp_rsp_q.push_back({req, err, dat});
  endtask

  task automatic start_req(input logic req, input logic we, input logic [31:0] adr,
                           input logic [15:0] sel, input logic [127:0] dat, output int v);
    @(posedge clk_i); #1;
    if (req) begin
      r1_we = we; r1_adr = adr; r1_sel = sel; r1_dat = dat; r1_valid = 1'b1;
    end else begin
      r0_we = we; r0_adr = adr; r0_sel = sel; r0_dat = dat; r0_valid = 1'b1;
    end
    v = cyc;
  endtask

  task automatic wait_ready(input logic req, output int c);
    bit ok = 1'b0;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (req ? r1_ready : r0_ready) begin
        ok = 1'b1;
        c = cyc;
        check("ready_other", req ? r0_ready : r1_ready, 1'b0);
        break;
      end
    end
    check("ready_seen", ok, 1'b1);
    @(posedge clk_i); #1;
    if (req) r1_valid = 1'b0; else r0_valid = 1'b0;
  endtask

  task automatic wait_stb(output int c);
    bit ok = 1'b0;
    c = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (m_stb) begin ok = 1'b1; c = cyc; break; end
    end
    check("stb_seen", ok, 1'b1);
  endtask

  // Called at the negedge of the strobe cycle; the response occupies cycle strobe+delay.
  task automatic send_rsp(input int delay, input logic rty, input logic [12:0] tid,
                          input logic [127:0] rdat);
    repeat (delay) @(posedge clk_i);
    #1;
    m_ack = !rty; m_rty = rty; m_rtid = tid; m_rdat = rdat;
    @(posedge clk_i); #1;
    m_ack = 1'b0; m_rty = 1'b0; m_rdat = '0;
  endtask

  task automatic wait_rsp(input int lim, output int c);
    bit ok = 1'b0;
    c = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_i);
      if (rsp0_valid || rsp1_valid) begin ok = 1'b1; c = cyc; break; end
    end
    check("rsp_seen", ok, 1'b1);
  endtask

  task automatic no_rsp_window(input string name, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (rsp0_valid || rsp1_valid) seen = 1'b1;
    end
    check(name, seen, 1'b0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ctrl"}, {r0_ready, r1_ready, rsp0_valid, rsp1_valid, rsp_err, busy,
                           m_cyc, m_stb, m_we}, 9'd0);
    check({pfx, "_buses"}, {|rsp_dat, |m_adr, |m_sel, |m_dat}, 4'd0);
    check({pfx, "_tid"}, m_tid, {PFX, 4'd0});
    check({pfx, "_state"}, dbg_state, 2'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v, rc, sc, s1, s2;
    logic [3:0] t;
    logic [3:0] tids[10];
    logic       g;

    rst_i = 1'b1;
    r0_valid = 0; r0_we = 0; r0_adr = '0; r0_sel = '0; r0_dat = '0;
    r1_valid = 0; r1_we = 0; r1_adr = '0; r1_sel = '0; r1_dat = '0;
    m_ack = 0; m_rty = 0; m_rtid = '0; m_rdat = '0;
    exp_tid = 4'd1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Single read from requester 1: ready at v+1, strobe at v+2, rsp one cycle after ack.
    t = exp_tid; exp_tid = nxt(exp_tid);
    push_stb(1'b0, 32'h000F_0000, 16'hFFFF, 128'd0, t);
    push_rsp(1'b1, 1'b0, 128'h1234);
    start_req(1'b1, 1'b0, 32'h000F_0000, 16'hFFFF, 128'd0, v);
    wait_ready(1'b1, rc);
    check("t1_ready_latency", rc - v, 1);
    wait_stb(sc);
    check("t1_stb_latency", sc - v, 2);
    check("t1_busy_on_stb", busy, 1'b1);
    send_rsp(3, 1'b0, {PFX, t}, 128'h1234);
    wait_rsp(10, rc);
    check("t1_rsp_latency", rc - sc, 4);

    // Both requesters held: grant order 0,0,0,0,1 repeating.
    for (int i = 0; i < 10; i++) begin
      g = (i % 5 == 4);
      tids[i] = exp_tid; exp_tid = nxt(exp_tid);
      if (g) push_stb(1'b0, 32'h0000_2000, 16'h00FF, 128'hBBBB, tids[i]);
      else   push_stb(1'b1, 32'h0000_1000, 16'hFF00, 128'hAAAA, tids[i]);
      push_rsp(g, 1'b0, 128'h100 + 128'(i));
    end
    start_req(1'b1, 1'b0, 32'h0000_2000, 16'h00FF, 128'hBBBB, v);
    r0_we = 1'b1; r0_adr = 32'h0000_1000; r0_sel = 16'hFF00; r0_dat = 128'hAAAA; r0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_stb(sc);
      if (i == 9) begin r0_valid = 1'b0; r1_valid = 1'b0; end
      send_rsp(2, 1'b0, {PFX, tids[i]}, 128'h100 + 128'(i));
      wait_rsp(10, rc);
    end

    // Retry: identical re-issue RTY_WAIT+1 cycles after the rty, single response.
    t = exp_tid; exp_tid = nxt(exp_tid);
    push_stb(1'b1, 32'h0000_3000, 16'h0F0F, 128'hDEAD_BEEF_0123_4567, t);
    push_stb(1'b1, 32'h0000_3000, 16'h0F0F, 128'hDEAD_BEEF_0123_4567, t);
    push_rsp(1'b0, 1'b0, 128'h77);
    start_req(1'b0, 1'b1, 32'h0000_3000, 16'h0F0F, 128'hDEAD_BEEF_0123_4567, v);
    wait_ready(1'b0, rc);
    wait_stb(s1);
    send_rsp(1, 1'b1, {PFX, t}, 128'd0);
    wait_stb(s2);
    check("retry_gap", s2 - (s1 + 1), RTY_WAIT + 1);
    send_rsp(1, 1'b0, {PFX, t}, 128'h77);
    wait_rsp(10, rc);
    no_rsp_window("retry_single_rsp", 5);

    // Mismatched tid is ignored, then timeout error TMO cycles after the strobe.
    t = exp_tid; exp_tid = nxt(exp_tid);
    push_stb(1'b0, 32'h0000_4000, 16'hFFFF, 128'd0, t);
    push_rsp(1'b0, 1'b1, 128'd0);
    start_req(1'b0, 1'b0, 32'h0000_4000, 16'hFFFF, 128'd0, v);
    wait_ready(1'b0, rc);
    wait_stb(sc);
    send_rsp(2, 1'b0, {PFX, t + 4'd1}, 128'h55);
    wait_rsp(TMO + 20, rc);
    check("tmo_latency", rc - sc, TMO);
    check("tmo_busy_at_rsp", busy, 1'b1);
    @(negedge clk_i);
    check("tmo_busy_drop", busy, 1'b0);
    check("tmo_err_hold", rsp_err, 1'b1);

    // Reset during WAIT: outputs cleared, late ack ignored, tid restarts at 1.
    t = exp_tid;
    push_stb(1'b0, 32'h0000_6000, 16'hFFFF, 128'd0, t);
    start_req(1'b0, 1'b0, 32'h0000_6000, 16'hFFFF, 128'd0, v);
    wait_ready(1'b0, rc);
    wait_stb(sc);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    exp_tid = 4'd1;
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("midwait");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_ack = 1'b1; m_rtid = {PFX, t}; m_rdat = 128'h99;
    @(posedge clk_i); #1;
    m_ack = 1'b0; m_rdat = '0;
    no_rsp_window("midwait_no_rsp", 5);

    // Sixteen transactions: tranid 1..15 then 1.
    for (int i = 0; i < 16; i++) begin
      t = exp_tid; exp_tid = nxt(exp_tid);
      push_stb(1'b0, 32'h0000_5000 + 32'(i * 16), 16'hFFFF, 128'd0, t);
      push_rsp(1'b0, 1'b0, 128'h500 + 128'(i));
      start_req(1'b0, 1'b0, 32'h0000_5000 + 32'(i * 16), 16'hFFFF, 128'd0, v);
      wait_ready(1'b0, rc);
      wait_stb(sc);
      send_rsp(1, 1'b0, {PFX, t}, 128'h500 + 128'(i));
      wait_rsp(10, rc);
    end
    check("wrap_last_tid", t, 4'd1);

    repeat (3) @(negedge clk_i);
    check("stb_queue_drained", exp_stb_q.size(), 0);
    check("rsp_queue_drained", exp_rsp_q.size(), 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
